bit_serializer: RTL

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 91 +++++++++
 1 files changed

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel word to serial bit stream with stall and done pulse
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pdata,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             stall,
   output logic             dout,
   output logic             en,
   output logic             busy,
   output logic             done
);

   localparam int CW   = $clog2(WIDTH);
   localparam int HEAD = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic             accept;

   // Status outputs decode straight from the registered state; only the bit
   // strobe looks at stall so a hold takes effect in the same cycle.
   assign load_ready = (state_q == IDLE) || (state_q == DONE);
   assign busy       = (state_q == SHIFT);
   assign done       = (state_q == DONE);
   assign accept     = load_valid && load_ready;
   assign en         = busy && !stall;
   assign dout       = busy ? shreg_q[HEAD] : 1'b0;

   // Next-state, shift register and bit counter; the counter stops at zero.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               state_d = SHIFT;
               shreg_d = pdata;
               cnt_d   = CW'(WIDTH - 1);
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (!stall) begin
               if (MSB_FIRST != 0) begin
                  shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
               end else begin
                  shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
               end
               if (cnt_q == '0) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers; reset aborts any word in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
